hps_rst_evt_ctrl: RTL

Fabric-side HPS reset-request and STM hardware-event controller, instantiated next to the soc_system HPS instance.
- Turns raw asynchronous board request inputs (buttons, watchdog lines) into clean, prioritised, fixed-length active-low cold/warm/debug reset requests toward the HPS.
- Turns a parametrised number of asynchronous fabric event lines into single-cycle STM hardware-event pulses.
- Gated by the HPS-to-fabric reset so nothing is issued while the HPS is held in reset.

---
 rtl/hps_rst_evt_pkg.sv | 42 ++++
 rtl/hps_rst_evt_ctrl_sync_debounce.sv | 55 +++++
 rtl/hps_rst_evt_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/hps_rst_evt_pkg.sv
// Shared types and helpers for the HPS reset-request / STM event controller.
//   req_code_t  : encoding of the reset request kind (also the last_req status code)
//   fsm_state_t : request sequencer states
//   SYNC_STAGES : depth of every asynchronous-input synchroniser
package hps_rst_evt_pkg;

    localparam int SYNC_STAGES = 2;

    typedef enum logic [1:0] {
        REQ_NONE  = 2'd0,
        REQ_COLD  = 2'd1,
        REQ_WARM  = 2'd2,
        REQ_DEBUG = 2'd3
    } req_code_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ASSERT  = 2'd1,
        HOLDOFF = 2'd2
    } fsm_state_t;

    // Bit mask {debug, warm, cold} of the request line selected by a code.
    function automatic logic [2:0] req_onehot(input req_code_t code);
        logic [2:0] mask;
        mask = 3'b000;
        case (code)
            REQ_COLD:  mask = 3'b001;
            REQ_WARM:  mask = 3'b010;
            REQ_DEBUG: mask = 3'b100;
            default:   mask = 3'b000;
        endcase
        return mask;
    endfunction

    // 8-bit saturating add of a small increment.
    function automatic logic [7:0] sat_add8(input logic [7:0] value, input logic [1:0] inc);
        logic [8:0] sum;
        sum = {1'b0, value} + {7'd0, inc};
        return sum[8] ? 8'hFF : sum[7:0];
    endfunction

endpackage

// File: rtl/hps_rst_evt_ctrl_sync_debounce.sv
// sync_debounce: synchroniser + debounce counter for one raw request line.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset
//   din    : raw asynchronous request, active-high
//   strobe : one-cycle pulse on each rising edge of the debounced level
// The debounced level only changes after DEBOUNCE_CYCLES consecutive
// synchronised samples disagree with it; any agreeing sample restarts the run.
import hps_rst_evt_pkg::*;

module sync_debounce #(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic strobe
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [SYNC_STAGES-1:0] sync_reg;
    logic [CW-1:0]          cnt_reg;
    logic                   level_reg;
    logic                   level_d_reg;
    logic                   sample;

    assign sample = sync_reg[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg    <= '0;
            cnt_reg     <= '0;
            level_reg   <= 1'b0;
            level_d_reg <= 1'b0;
        end else begin
            sync_reg    <= {sync_reg[SYNC_STAGES-2:0], din};
            level_d_reg <= level_reg;
            if (sample != level_reg) begin
                // The sample that completes the run flips the level, so the
                // counter tops out at DEBOUNCE_CYCLES-1 and never wraps.
                if (cnt_reg == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level_reg <= ~level_reg;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CW'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
        end
    end

    assign strobe = level_reg & ~level_d_reg;

endmodule

// File: rtl/hps_rst_evt_ctrl.sv
// hps_rst_evt_ctrl: fabric-side HPS reset-request and STM hardware-event controller.
//   clk_clk               : system clock
//   reset_reset_n         : asynchronous active-low reset
//   h2f_reset_n           : HPS-to-fabric reset (low = HPS held in reset), async
//   req_cold/warm/debug   : raw async reset requests, active-high
//   evt_in                : raw async event lines, rising edge significant
//   f2h_*_reset_req_n     : fixed-length active-low reset requests to the HPS
//   stm_hwevents          : single-cycle event pulses to the HPS STM
//   busy                  : high while a request pulse or its hold-off is running
// Optional build macro HPS_RST_EVT_STATUS_EN adds status outputs:
//   req_cnt_cold/warm/debug (pulses issued), drop_cnt (dropped strobes),
//   last_req (code of the most recent pulse); all 8-bit saturating except last_req.
import hps_rst_evt_pkg::*;

module hps_rst_evt_ctrl #(
    parameter int NUM_EVENTS      = 28,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int PULSE_CYCLES    = 16,
    parameter int HOLDOFF_CYCLES  = 1024
) (
    input  logic                  clk_clk,
    input  logic                  reset_reset_n,
    input  logic                  h2f_reset_n,
    input  logic                  req_cold,
    input  logic                  req_warm,
    input  logic                  req_debug,
    input  logic [NUM_EVENTS-1:0] evt_in,
    output logic                  f2h_cold_reset_req_n,
    output logic                  f2h_warm_reset_req_n,
    output logic                  f2h_debug_reset_req_n,
    output logic [NUM_EVENTS-1:0] stm_hwevents,
`ifdef HPS_RST_EVT_STATUS_EN
    output logic [7:0]            req_cnt_cold,
    output logic [7:0]            req_cnt_warm,
    output logic [7:0]            req_cnt_debug,
    output logic [7:0]            drop_cnt,
    output logic [1:0]            last_req,
`endif
    output logic                  busy
);

    localparam int PW = $clog2(PULSE_CYCLES + 1);
    // A zero hold-off still needs a legal (unused) counter width.
    localparam int HW = (HOLDOFF_CYCLES > 0) ? $clog2(HOLDOFF_CYCLES + 1) : 1;

    // ---------------- HPS reset synchroniser ----------------
    logic [SYNC_STAGES-1:0] h2f_sync_reg;
    logic                   h2f_ok;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            h2f_sync_reg <= '0;
        end else begin
            h2f_sync_reg <= {h2f_sync_reg[SYNC_STAGES-2:0], h2f_reset_n};
        end
    end

    assign h2f_ok = h2f_sync_reg[SYNC_STAGES-1];

    // ---------------- request debouncers ----------------
    // Bit 0 = cold, 1 = warm, 2 = debug.
    logic [2:0] req_raw;
    logic [2:0] req_strobe;

    assign req_raw = {req_debug, req_warm, req_cold};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_req
            sync_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_sync_debounce (
                .clk   (clk_clk),
                .rst_n (reset_reset_n),
                .din   (req_raw[gi]),
                .strobe(req_strobe[gi])
            );
        end
    endgenerate

    // ---------------- request sequencer ----------------
    fsm_state_t    state_reg;
    logic [PW-1:0] pulse_cnt_reg;
    logic [HW-1:0] hold_cnt_reg;
    logic [2:0]    req_n_reg;
    req_code_t     winner;
    logic          accept;

    always_comb begin
        winner = REQ_NONE;
        if (req_strobe[0]) begin
            winner = REQ_COLD;
        end else if (req_strobe[1]) begin
            winner = REQ_WARM;
        end else if (req_strobe[2]) begin
            winner = REQ_DEBUG;
        end
    end

    // Strobes are only honoured when idle and the HPS is out of reset;
    // everything else (losers, busy, HPS in reset) is dropped.
    assign accept = (state_reg == IDLE) && (|req_strobe) && h2f_ok;

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            state_reg     <= IDLE;
            pulse_cnt_reg <= '0;
            hold_cnt_reg  <= '0;
            req_n_reg     <= 3'b111;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        state_reg     <= ASSERT;
                        pulse_cnt_reg <= PW'(PULSE_CYCLES);
                        req_n_reg     <= ~req_onehot(winner);
                    end
                end
                ASSERT: begin
                    // h2f_reset_n is deliberately ignored: a started pulse completes.
                    if (pulse_cnt_reg <= PW'(1)) begin
                        req_n_reg <= 3'b111;
                        if (HOLDOFF_CYCLES == 0) begin
                            state_reg <= IDLE;
                        end else begin
                            state_reg    <= HOLDOFF;
                            hold_cnt_reg <= HW'(HOLDOFF_CYCLES);
                        end
                    end else begin
                        pulse_cnt_reg <= pulse_cnt_reg - PW'(1);
                    end
                end
                HOLDOFF: begin
                    if (hold_cnt_reg <= HW'(1)) begin
                        state_reg <= IDLE;
                    end else begin
                        hold_cnt_reg <= hold_cnt_reg - HW'(1);
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    req_n_reg <= 3'b111;
                end
            endcase
        end
    end

    assign f2h_cold_reset_req_n  = req_n_reg[0];
    assign f2h_warm_reset_req_n  = req_n_reg[1];
    assign f2h_debug_reset_req_n = req_n_reg[2];
    assign busy                  = (state_reg != IDLE);

    // ---------------- STM hardware events ----------------
    generate
        for (genvar gi = 0; gi < NUM_EVENTS; gi++) begin : g_evt
            logic [SYNC_STAGES-1:0] evt_sync_reg;
            logic                   evt_d_reg;
            logic                   evt_pulse_reg;

            always_ff @(posedge clk_clk or negedge reset_reset_n) begin
                if (!reset_reset_n) begin
                    evt_sync_reg  <= '0;
                    evt_d_reg     <= 1'b0;
                    evt_pulse_reg <= 1'b0;
                end else begin
                    evt_sync_reg  <= {evt_sync_reg[SYNC_STAGES-2:0], evt_in[gi]};
                    evt_d_reg     <= evt_sync_reg[SYNC_STAGES-1];
                    // The edge is consumed even while gated, so a line that
                    // stays high across HPS reset release gives no late pulse.
                    evt_pulse_reg <= evt_sync_reg[SYNC_STAGES-1] & ~evt_d_reg & h2f_ok;
                end
            end

            assign stm_hwevents[gi] = evt_pulse_reg;
        end
    endgenerate

`ifdef HPS_RST_EVT_STATUS_EN
    // ---------------- status counters ----------------
    logic [1:0] strobe_cnt;
    logic [1:0] drop_inc;
    logic [7:0] req_cnt_cold_reg;
    logic [7:0] req_cnt_warm_reg;
    logic [7:0] req_cnt_debug_reg;
    logic [7:0] drop_cnt_reg;
    req_code_t  last_req_reg;

    assign strobe_cnt = 2'(req_strobe[0]) + 2'(req_strobe[1]) + 2'(req_strobe[2]);
    assign drop_inc   = strobe_cnt - 2'(accept);

    always_ff @(posedge clk_clk or negedge reset_reset_n) begin
        if (!reset_reset_n) begin
            req_cnt_cold_reg  <= '0;
            req_cnt_warm_reg  <= '0;
            req_cnt_debug_reg <= '0;
            drop_cnt_reg      <= '0;
            last_req_reg      <= REQ_NONE;
        end else begin
            drop_cnt_reg <= sat_add8(drop_cnt_reg, drop_inc);
            if (accept) begin
                last_req_reg <= winner;
                case (winner)
                    REQ_COLD:  req_cnt_cold_reg  <= sat_add8(req_cnt_cold_reg, 2'd1);
                    REQ_WARM:  req_cnt_warm_reg  <= sat_add8(req_cnt_warm_reg, 2'd1);
                    REQ_DEBUG: req_cnt_debug_reg <= sat_add8(req_cnt_debug_reg, 2'd1);
                    default: ;
                endcase
            end
        end
    end

    assign req_cnt_cold  = req_cnt_cold_reg;
    assign req_cnt_warm  = req_cnt_warm_reg;
    assign req_cnt_debug = req_cnt_debug_reg;
    assign drop_cnt      = drop_cnt_reg;
    assign last_req      = last_req_reg;
`endif

endmodule
